// File: rtl/sha3_padder.sv
// Byte-stream to rate-block packer for the keccak sponge: writes message bytes
// MSB-first into an r-bit block and appends 0x60 .. 0x01 domain/pad10*1 padding.
module sha3_padder #(
    parameter int unsigned d = 256,
    parameter int unsigned r = 1600 - 2 * d
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         in_ready,
    output logic [r-1:0] block,
    output logic         block_valid,
    output logic         block_first,
    output logic         block_last,
    input  logic         block_ready
);
    localparam int unsigned NB = r / 8;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
    localparam int unsigned LAST_LSB = r - 8 * NB;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          need_pad_q, need_pad_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic          ready_q, ready_d;
    logic [r-1:0]  block_q, block_d;

    // State and datapath registers; reset drops any partial block and pending pad
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            need_pad_q <= 1'b0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            block_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            need_pad_q <= need_pad_d;
            first_q    <= first_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            block_q    <= block_d;
        end
    end

    // Next-state, byte placement and padding
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        need_pad_d = need_pad_q;
        first_d    = first_q;
        last_d     = last_q;
        valid_d    = valid_q;
        block_d    = block_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (in_keep) begin
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (CW'(i) == cnt_q) begin
                                block_d[r-1-8*i -: 8] = in_data;
                            end
                        end
                    end
                    if (in_keep && (cnt_q == LAST_BYTE)) begin
                        // Block full; a last byte here still owes a pad-only block
                        state_d    = OUT;
                        cnt_d      = '0;
                        valid_d    = 1'b1;
                        need_pad_d = in_last;
                    end else if (in_last) begin
                        state_d = PAD;
                        if (in_keep) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (in_keep) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PAD: begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (CW'(i) == cnt_q) begin
                        block_d[r-1-8*i -: 8] = 8'h60;
                    end else if (CW'(i) > cnt_q) begin
                        block_d[r-1-8*i -: 8] = 8'h00;
                    end
                end
                block_d[LAST_LSB +: 8] = block_d[LAST_LSB +: 8] | 8'h01;
                state_d    = OUT;
                cnt_d      = '0;
                valid_d    = 1'b1;
                last_d     = 1'b1;
                need_pad_d = 1'b0;
            end
            OUT: begin
                if (block_ready) begin
                    valid_d = 1'b0;
                    first_d = last_q;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = need_pad_q ? PAD : FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        ready_d = (state_d == FILL);
    end

    assign in_ready    = ready_q;
    assign block       = block_q;
    assign block_valid = valid_q;
    assign block_first = first_q;
    assign block_last  = last_q;

endmodule

// File: tb/tb_sha3_padder.sv
// Scoreboard bench for sha3_padder: expected blocks come from an independent
// pad-then-split model of each message and are compared as blocks are consumed.
module tb_sha3_padder;
    localparam int unsigned D  = 256;
    localparam int unsigned RB = 1600 - 2 * D;
    localparam int unsigned R  = RB / 8;

    typedef struct {
        logic [RB-1:0] data;
        logic          first;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_keep = 1'b0;
    logic          in_last = 1'b0;
    logic          block_ready = 1'b0;
    logic          in_ready;
    logic [RB-1:0] block;
    logic          block_valid;
    logic          block_first;
    logic          block_last;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sha3_padder #(.d(D), .r(RB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_keep    (in_keep),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .block      (block),
        .block_valid(block_valid),
        .block_first(block_first),
        .block_last (block_last),
        .block_ready(block_ready)
    );

    always @(posedge clk) begin
        if (reset && in_valid && !in_keep) begin
            assert (in_last) else $error("illegal beat: in_keep=0 without in_last");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model: append 0x60, zero-fill to a multiple of R (at least one pad byte), OR 0x01 into the final byte
    task automatic expect_msg(input logic [7:0] msg[$]);
        int unsigned n = msg.size();
        int unsigned nblk = n / R + 1;
        logic [7:0] padded[$];
        exp_t e;
        for (int unsigned i = 0; i < nblk * R; i++) begin
            padded.push_back(i < n ? msg[i] : (i == n ? 8'h60 : 8'h00));
        end
        padded[nblk*R-1] = padded[nblk*R-1] | 8'h01;
        for (int unsigned b = 0; b < nblk; b++) begin
            for (int unsigned i = 0; i < R; i++) begin
                e.data[RB-1-8*i -: 8] = padded[b*R+i];
            end
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [7:0] b, input logic k, input logic l);
        int budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_keep  = k;
        in_last  = l;
        while (!in_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        int n = msg.size();
        if (n == 0) send_beat(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) send_beat(msg[i], 1'b1, i == n - 1);
    endtask

    task automatic get_block(output logic [RB-1:0] data, output logic f, output logic l, output logic ok);
        int budget = 0;
        @(negedge clk);
        while (!block_valid && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        ok   = block_valid;
        data = block;
        f    = block_first;
        l    = block_last;
        if (ok) begin
            block_ready = 1'b1;
            @(posedge clk);
            #1 block_ready = 1'b0;
        end
    endtask

    function automatic logic [7:0] abc_byte(input int i);
        logic [23:0] s;
        s = 24'h616263;
        return s[23-8*i -: 8];
    endfunction

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_keep  = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_keep  = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (block_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", block_valid); end
        total++; if (block_first !== 1'b1) begin bad++; $display("FAIL reset_first got=%b exp=1", block_first); end
        total++; if (block_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", block_last); end
        total++; if (block !== '0) begin bad++; $display("FAIL reset_block got=%h exp=0", block); end
    endtask

    task automatic test_empty();
        logic [7:0] m[$];
        logic [RB-1:0] got;
        logic gf, gl, ok;
        exp_t e;
        expect_msg(m);
        send_msg(m);
        idle();
        get_block(got, gf, gl, ok);
        e = sb.pop_front();
        total++; if (!ok || got !== e.data) begin bad++; $display("FAIL empty_data ok=%b got=%h exp=%h", ok, got, e.data); end
        total++; if (gf !== 1'b1 || gl !== 1'b1) begin bad++; $display("FAIL empty_flags got=%b%b exp=11", gf, gl); end
    endtask

    task automatic run_abc(input string tag);
        logic [7:0] m[$];
        logic [RB-1:0] got;
        logic gf, gl, ok;
        exp_t e;
        for (int i = 0; i < 3; i++) m.push_back(abc_byte(i));
        expect_msg(m);
        send_msg(m);
        #1;
        total++; if (block_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid got=%b exp=0", tag, block_valid); end
        idle();
        @(posedge clk);
        #1;
        total++; if (block_valid !== 1'b1) begin bad++; $display("FAIL %s_latency got=%b exp=1", tag, block_valid); end
        get_block(got, gf, gl, ok);
        e = sb.pop_front();
        total++; if (!ok || got !== e.data) begin bad++; $display("FAIL %s_data ok=%b got=%h exp=%h", tag, ok, got, e.data); end
        total++; if (gf !== e.first || gl !== e.last) begin bad++; $display("FAIL %s_flags got=%b%b exp=%b%b", tag, gf, gl, e.first, e.last); end
    endtask

    task automatic test_long(input int n);
        logic [7:0] m[$];
        logic [RB-1:0] got;
        logic gf, gl, ok;
        exp_t e;
        int nblk;
        for (int i = 0; i < n; i++) m.push_back(8'(i) ^ 8'h5A);
        expect_msg(m);
        nblk = sb.size();
        send_msg(m);
        idle();
        for (int b = 0; b < nblk; b++) begin
            get_block(got, gf, gl, ok);
            e = sb.pop_front();
            total++; if (!ok || got !== e.data) begin bad++; $display("FAIL len%0d_blk%0d_data ok=%b got=%h exp=%h", n, b, ok, got, e.data); end
            total++; if (gf !== e.first || gl !== e.last) begin bad++; $display("FAIL len%0d_blk%0d_flags got=%b%b exp=%b%b", n, b, gf, gl, e.first, e.last); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] m[$];
        logic [7:0] head[$];
        logic [7:0] tail[$];
        logic [RB-1:0] snap, got;
        logic gf, gl, ok;
        exp_t e;
        for (int i = 0; i < 139; i++) m.push_back(8'($urandom));
        for (int i = 0; i < 136; i++) head.push_back(m[i]);
        for (int i = 136; i < 139; i++) tail.push_back(m[i]);
        expect_msg(m);
        for (int i = 0; i < 136; i++) send_beat(head[i], 1'b1, 1'b0);
        #1;
        total++; if (block_valid !== 1'b1) begin bad++; $display("FAIL bp_full_latency got=%b exp=1", block_valid); end
        idle();
        snap = block;
        e = sb.pop_front();
        total++; if (snap !== e.data || block_first !== 1'b1 || block_last !== 1'b0) begin
            bad++; $display("FAIL bp_blockA got=%h f=%b l=%b exp=%h f=1 l=0", snap, block_first, block_last, e.data);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (block !== snap || in_ready !== 1'b0 || block_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold cycle=%0d in_ready=%b valid=%b changed=%b exp in_ready=0 valid=1 changed=0", c, in_ready, block_valid, block !== snap);
            end
        end
        block_ready = 1'b1;
        @(posedge clk);
        #1 block_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || block_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release in_ready=%b valid=%b exp in_ready=1 valid=0", in_ready, block_valid);
        end
        send_msg(tail);
        idle();
        get_block(got, gf, gl, ok);
        e = sb.pop_front();
        total++; if (!ok || got !== e.data) begin bad++; $display("FAIL bp_blockB ok=%b got=%h exp=%h", ok, got, e.data); end
        total++; if (gf !== 1'b0 || gl !== 1'b1) begin bad++; $display("FAIL bp_blockB_flags got=%b%b exp=01", gf, gl); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 50; i++) send_beat(8'(i + 3), 1'b1, 1'b0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        total++; if (block_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_state valid=%b in_ready=%b exp valid=0 in_ready=1", block_valid, in_ready);
        end
        run_abc("midreset_abc");
        repeat (5) @(negedge clk);
        total++; if (block_valid !== 1'b0 || sb.size() != 0) begin
            bad++; $display("FAIL midreset_extra valid=%b pending=%0d exp valid=0 pending=0", block_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msgs[3][$];
        int nexp;
        for (int k = 0; k < 3; k++) begin
            int len = (k == 0) ? 0 : int'($urandom_range(1, 140));
            for (int i = 0; i < len; i++) msgs[k].push_back(8'($urandom));
            expect_msg(msgs[k]);
        end
        nexp = sb.size();
        fork
            begin
                for (int k = 0; k < 3; k++) send_msg(msgs[k]);
                idle();
            end
            begin
                logic [RB-1:0] got;
                logic gf, gl, ok;
                exp_t e;
                for (int b = 0; b < nexp; b++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    get_block(got, gf, gl, ok);
                    e = sb.pop_front();
                    total++; if (!ok || got !== e.data) begin bad++; $display("FAIL b2b_blk%0d_data ok=%b got=%h exp=%h", b, ok, got, e.data); end
                    total++; if (gf !== e.first || gl !== e.last) begin bad++; $display("FAIL b2b_blk%0d_flags got=%b%b exp=%b%b", b, gf, gl, e.first, e.last); end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_empty();
        run_abc("abc");
        test_long(135);
        test_long(136);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
